fc_pe_sequencer: RTL and testbench

//  Drives one FC processing element (float32 MAC with accumulator clear) for a full FC layer.

---
 rtl/fc_pkg.sv | 21 ++
 rtl/fc_step_timer.sv | 26 ++
 rtl/fc_pe_sequencer.sv | 118 +++++++++++
 tb/tb_fc_pe_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and helpers for the FC processing-element sequencer.
package fc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_HOLD,
    ST_DRAIN,
    ST_EMIT,
    ST_FIN
  } fc_state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // Address/counter width for a range of n values; never narrower than one bit.
  function automatic int fc_clog2(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fc_step_timer.sv
// Loadable down-counter; expired is high once the count has reached zero.
module fc_step_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/fc_pe_sequencer.sv
// Sequences one FC layer through a single MAC processing element: clears the PE,
// streams activation/weight pairs from the layer RAMs, then hands each neuron result downstream.
module fc_pe_sequencer
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int N_IN         = 16,
  parameter int N_OUT        = 4,
  parameter int STEP_CYCLES  = 2,
  parameter int DRAIN_CYCLES = 3,
  localparam int IAW = fc_clog2(N_IN),
  localparam int WAW = fc_clog2(N_IN * N_OUT),
  localparam int IDW = fc_clog2(N_OUT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [IAW-1:0]        in_addr,
  input  logic [DATA_WIDTH-1:0] in_rdata,
  output logic [WAW-1:0]        w_addr,
  input  logic [DATA_WIDTH-1:0] w_rdata,
  output logic [DATA_WIDTH-1:0] input_fc,
  output logic [DATA_WIDTH-1:0] iweight_FC,
  output logic                  start_FC,
  input  logic [DATA_WIDTH-1:0] output_fc,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [IDW-1:0]        res_idx,
  output logic                  res_valid,
  input  logic                  res_ready,
  output fc_state_e             state_dbg
);

  localparam int TMAX = (STEP_CYCLES > DRAIN_CYCLES) ? STEP_CYCLES : DRAIN_CYCLES;
  localparam int TW   = fc_clog2(TMAX);

  fc_state_e             state_q, state_d;
  logic [IAW-1:0]        i_q;
  logic [IDW-1:0]        neuron_q;
  logic [DATA_WIDTH-1:0] res_data_q;
  logic                  tmr_load, tmr_expired;
  logic [TW-1:0]         tmr_val;
  logic                  last_i, last_n;

  assign last_i = (i_q == IAW'(N_IN - 1));
  assign last_n = (neuron_q == IDW'(N_OUT - 1));

  // FETCH arms the hold window; the final HOLD cycle arms the drain window.
  assign tmr_load = (state_q == ST_FETCH) || (state_q == ST_HOLD && tmr_expired && last_i);
  assign tmr_val  = (state_q == ST_FETCH) ? TW'(STEP_CYCLES - 1) : TW'(DRAIN_CYCLES - 1);

  fc_step_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_FETCH;
      ST_FETCH: state_d = ST_HOLD;
      ST_HOLD:  if (tmr_expired) state_d = last_i ? ST_DRAIN : ST_FETCH;
      ST_DRAIN: if (tmr_expired) state_d = ST_EMIT;
      ST_EMIT:  if (res_ready) state_d = last_n ? ST_FIN : ST_CLEAR;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_q        <= '0;
      neuron_q   <= '0;
      res_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) neuron_q <= '0;
        ST_CLEAR: i_q <= '0;
        ST_HOLD:  if (tmr_expired && !last_i) i_q <= i_q + 1'b1;
        ST_DRAIN: if (tmr_expired) res_data_q <= output_fc;
        ST_EMIT:  if (res_ready && !last_n) neuron_q <= neuron_q + 1'b1;
        default:  ;
      endcase
    end
  end

  // The address stays on i through HOLD, so the RAM output register keeps the
  // pair stable for the whole window; outside HOLD the PE sees +0 * +0.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_FIN);
    start_FC   = (state_q == ST_CLEAR);
    res_valid  = (state_q == ST_EMIT);
    input_fc   = DATA_WIDTH'(FP_ZERO);
    iweight_FC = DATA_WIDTH'(FP_ZERO);
    if (state_q == ST_HOLD) begin
      input_fc   = in_rdata;
      iweight_FC = w_rdata;
    end
  end

  assign in_addr   = i_q;
  assign w_addr    = WAW'(int'(neuron_q) * N_IN + int'(i_q));
  assign res_data  = res_data_q;
  assign res_idx   = neuron_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fc_pe_sequencer.sv
// Bench for fc_pe_sequencer: RAM models, an integer-valued float MAC PE model and a result scoreboard.
module tb_fc_pe_sequencer;
  import fc_pkg::*;

  localparam int DW    = 32;
  localparam int N_IN  = 4;
  localparam int N_OUT = 4;
  localparam int STEP  = 2;
  localparam int DRAIN = 3;
  localparam int IAW   = 2;
  localparam int WAW   = 4;
  localparam int IDW   = 2;
  localparam int SBW   = DW + IDW;
  localparam int LAT   = 1 + N_IN * (1 + STEP) + DRAIN;

  localparam logic [31:0] W_TAB [N_OUT] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
  localparam logic [31:0] R_TAB [N_OUT] = '{32'h4080_0000, 32'h4100_0000, 32'h4140_0000, 32'h4180_0000};

  logic            clk, reset_n, start;
  logic            busy, done, start_FC, res_valid, res_ready;
  logic [IAW-1:0]  in_addr;
  logic [WAW-1:0]  w_addr;
  logic [DW-1:0]   in_rdata, w_rdata, input_fc, iweight_FC, output_fc, res_data;
  logic [IDW-1:0]  res_idx;
  fc_state_e       state_dbg;

  fc_pe_sequencer #(
    .DATA_WIDTH(DW), .N_IN(N_IN), .N_OUT(N_OUT), .STEP_CYCLES(STEP), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .in_rdata(in_rdata), .w_addr(w_addr), .w_rdata(w_rdata),
    .input_fc(input_fc), .iweight_FC(iweight_FC), .start_FC(start_FC), .output_fc(output_fc),
    .res_data(res_data), .res_idx(res_idx), .res_valid(res_valid), .res_ready(res_ready),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- float helpers (non-negative integer values) ----------------
  function automatic logic [31:0] int_to_fp(input int unsigned v);
    int p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    p = 0;
    for (int b = 0; b < 32; b++) if (v[b]) p = b;
    m = v << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int unsigned fp_to_int(input logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'h0, 1'b1, f[22:0]};
    return m >> (23 - e);
  endfunction

  // ---------------- RAM and PE models ----------------
  logic [DW-1:0] act_mem [N_IN];
  logic [DW-1:0] wt_mem  [N_IN*N_OUT];

  always @(posedge clk) begin
    in_rdata <= act_mem[in_addr];
    w_rdata  <= wt_mem[w_addr];
  end

  // MAC adds each operand pair once, when it first appears; result visible 3 cycles later.
  int unsigned acc, d1, d2;
  bit          prev_nz;
  always @(posedge clk) begin
    prev_nz <= (input_fc != 0) || (iweight_FC != 0);
    if (start_FC) acc <= 0;
    else if (((input_fc != 0) || (iweight_FC != 0)) && !prev_nz)
      acc <= acc + fp_to_int(input_fc) * fp_to_int(iweight_FC);
    d1        <= acc;
    d2        <= d1;
    output_fc <= int_to_fp(d2);
  end

  // ---------------- scoreboard ----------------
  logic [SBW-1:0] exp_q[$];
  logic [SBW-1:0] e;
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt, res_cnt, clr_cnt, opnz_cnt, lat;
  bit lat_on;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    lat_on = 0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (start_FC) begin
          clr_cnt++;
          lat    = 0;
          lat_on = 1;
        end else if (lat_on) begin
          lat++;
        end
        if (res_valid && lat_on) begin
          chk("latency", lat, LAT);
          lat_on = 0;
        end
        if ((start_FC || res_valid || state_dbg == ST_DRAIN) && (input_fc != 0 || iweight_FC != 0))
          opnz_cnt++;
        if (done) done_cnt++;
        if (res_valid && !res_ready) begin
          if (exp_q.size() > 0) chk("stall_data", res_data, exp_q[0][DW-1:0]);
          chk("stall_state", DW'(state_dbg), DW'(ST_EMIT));
        end
        if (res_valid && res_ready) begin
          res_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_result", res_data, '0);
          end else begin
            e = exp_q.pop_front();
            chk("res_data", res_data, e[DW-1:0]);
            chk("res_idx", DW'(res_idx), DW'(e[SBW-1:DW]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_const(input logic [31:0] x);
    for (int i = 0; i < N_IN; i++) act_mem[i] = x;
  endtask

  task automatic load_table_weights();
    for (int k = 0; k < N_OUT; k++)
      for (int i = 0; i < N_IN; i++) wt_mem[k*N_IN + i] = W_TAB[k];
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // mode 0: ready high; 1: 20-cycle stall on neuron 1; 2: random ready plus stray starts
  task automatic run_layer(input int mode);
    int  stall_left;
    int  cyc;
    bit  finished;
    done_cnt = 0; res_cnt = 0; clr_cnt = 0; opnz_cnt = 0;
    stall_left = (mode == 1) ? 20 : 0;
    cyc = 0;
    finished = 0;
    pulse_start();
    chk("busy_after_start", DW'(busy), 1);
    while (!finished && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      start = (mode == 2 && (cyc == 10 || cyc == 40));
      if (stall_left > 0 && res_valid && res_idx == 1) begin
        res_ready = 1'b0;
        stall_left--;
      end else if (mode == 2) begin
        res_ready = 1'($urandom_range(0, 1));
      end else begin
        res_ready = 1'b1;
      end
      if (done_cnt > 0) finished = 1;
    end
    start = 1'b0;
    res_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("layer_done", DW'(finished), 1);
    chk("done_pulses", done_cnt, 1);
    chk("result_count", res_cnt, N_OUT);
    chk("clear_pulses", clr_cnt, N_OUT);
    chk("operands_zero", opnz_cnt, 0);
    chk("queue_empty", exp_q.size(), 0);
    chk("busy_after_done", DW'(busy), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, DW'(busy), 0);
    chk({tag, "_done"}, DW'(done), 0);
    chk({tag, "_in_addr"}, DW'(in_addr), 0);
    chk({tag, "_w_addr"}, DW'(w_addr), 0);
    chk({tag, "_input_fc"}, input_fc, 0);
    chk({tag, "_iweight"}, iweight_FC, 0);
    chk({tag, "_start_fc"}, DW'(start_FC), 0);
    chk({tag, "_res_valid"}, DW'(res_valid), 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_idx"}, DW'(res_idx), 0);
    chk({tag, "_state"}, DW'(state_dbg), DW'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int unsigned sum;
    int          tries;
    bit          hit;
    reset_n   = 1'b0;
    start     = 1'b0;
    res_ready = 1'b1;
    load_const(32'h3F80_0000);
    for (int j = 0; j < N_IN*N_OUT; j++) wt_mem[j] = 32'h4000_0000;
    #12;
    check_idle_outputs("reset");
    @(negedge clk) reset_n = 1'b1;

    // all x=1.0, w=2.0 -> every neuron 8.0
    for (int k = 0; k < N_OUT; k++) exp_q.push_back({IDW'(k), 32'h4100_0000});
    run_layer(0);

    // neuron k weights k+1 -> 4,8,12,16, with a long stall on neuron 1
    load_table_weights();
    for (int k = 0; k < N_OUT; k++) exp_q.push_back({IDW'(k), R_TAB[k]});
    run_layer(1);

    // random small integers, random backpressure, stray starts mid-run
    for (int i = 0; i < N_IN; i++) act_mem[i] = int_to_fp($urandom_range(0, 15));
    for (int j = 0; j < N_IN*N_OUT; j++) wt_mem[j] = int_to_fp($urandom_range(1, 15));
    for (int k = 0; k < N_OUT; k++) begin
      sum = 0;
      for (int i = 0; i < N_IN; i++)
        sum += fp_to_int(act_mem[i]) * fp_to_int(wt_mem[k*N_IN + i]);
      exp_q.push_back({IDW'(k), int_to_fp(sum)});
    end
    run_layer(2);

    // async reset in the middle of neuron 1's third HOLD window
    load_const(32'h3F80_0000);
    load_table_weights();
    for (int k = 0; k < N_OUT; k++) exp_q.push_back({IDW'(k), R_TAB[k]});
    done_cnt = 0;
    pulse_start();
    hit = 0;
    tries = 0;
    while (!hit && tries < 500) begin
      @(posedge clk); #1;
      tries++;
      if (state_dbg == ST_HOLD && in_addr == 2 && res_idx == 1) hit = 1;
    end
    chk("reached_mid_hold", DW'(hit), 1);
    #2 reset_n = 1'b0;
    #1;
    check_idle_outputs("midrun_reset");
    chk("no_done_on_abort", done_cnt, 0);
    exp_q.delete();
    lat_on = 0;
    @(negedge clk) reset_n = 1'b1;

    // fresh run after the abort
    for (int k = 0; k < N_OUT; k++) exp_q.push_back({IDW'(k), R_TAB[k]});
    run_layer(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
